// File: rtl/divider_seq.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH+1 edges start-to-done.
// Divide-by-zero short-circuits to DONE with an all-ones quotient and the dividend as remainder.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one restoring shift/subtract step per edge, WIDTH steps
// DONE  | single-cycle result-valid pulse; start ignored
module divider_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remd;
  logic             r_dbz;

  logic [WIDTH:0]   w_r_sh;
  logic [WIDTH-1:0] w_diff;
  logic             w_bc;
  logic             w_borrow;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_q_next;

  // Stored remainder is always below the divisor, so only WIDTH bits are kept;
  // the shifted value's top bit only feeds the final borrow.
  always_comb begin
    w_r_sh = {r_rem, r_q[WIDTH-1]};
    w_diff = '0;
    w_bc   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      w_diff[i] = w_r_sh[i] ^ r_d[i] ^ w_bc;
      w_bc      = (~w_r_sh[i] & r_d[i]) | (~(w_r_sh[i] ^ r_d[i]) & w_bc);
    end
    w_borrow = ~w_r_sh[WIDTH] & w_bc;
    w_r_next = w_borrow ? w_r_sh[WIDTH-1:0] : w_diff;
    w_q_next = {r_q[WIDTH-2:0], ~w_borrow};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = (divisor == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (r_cnt == LAST) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d    <= '0;
      r_q    <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_remd <= '0;
      r_dbz  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              r_d   <= divisor;
              r_q   <= dividend;
              r_rem <= '0;
              r_cnt <= '0;
              r_dbz <= 1'b0;
            end else begin
              r_quot <= '1;
              r_remd <= dividend;
              r_dbz  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_r_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_quot <= w_q_next;
            r_remd <= w_r_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quot;
  assign remainder   = r_remd;
  assign div_by_zero = r_dbz;

endmodule

// File: doc/divider_seq.md
# divider_seq

Sequential restoring divider, the inverse companion of the shift-and-add multiplier. It divides an unsigned WIDTH-bit dividend by an unsigned WIDTH-bit divisor and produces one quotient bit per clock. It sits beside the multiplier datapath: it takes operands from the switch/operand registers and drives the display/result registers.

## Interface

- WIDTH, 8: operand, quotient and remainder width in bits (≥2).

- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  WIDTH  unsigned dividend; captured on the accepting edge.
- divisor  input  WIDTH  unsigned divisor; captured on the accepting edge.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse: result valid.
- quotient  output  WIDTH  registered quotient; holds until the next result.
- remainder  output  WIDTH  registered remainder; holds until the next result.
- div_by_zero  output  1  high with done when divisor was 0; holds until the next accepted start.

## Operation

- States: IDLE, RUN, DONE.
- Reset (rst_n=0 at an edge): state IDLE. busy, done, div_by_zero, quotient and remainder all 0. The iteration counter and internal registers are cleared. Reset wins over every other event, including mid-RUN; an aborted division produces no done.
- IDLE with start=1:
  - divisor≠0: latch divisor into D, dividend into shift register Q. Clear partial remainder R (WIDTH+1 bits) and counter. Clear div_by_zero. Go to RUN.
  - divisor=0: no iteration. Go to DONE with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
- RUN, each edge performs one restoring step:
  - R ← {R[WIDTH-1:0], Q[WIDTH-1]}, Q ← Q<<1.
  - T = R − {0,D} via a WIDTH+1-bit ripple-borrow subtractor (R + ~D + 1).
  - If no borrow (R≥D): R ← T, Q[0] ← 1. Otherwise R is unchanged and Q[0] ← 0.
  - Counter increments. On the WIDTH-th step, load quotient←final Q and remainder←final R[WIDTH-1:0], then go to DONE.
- DONE: lasts exactly one cycle with done=1, then returns to IDLE. A start in the DONE cycle is ignored.
- start while busy is ignored; operand changes during RUN have no effect.
- Arithmetic is unsigned only. Invariant: dividend = quotient·divisor + remainder, with remainder < divisor (divisor≠0).

## Timing

- Let edge 0 be the edge that accepts start.
- Normal path:
  - busy=1 in the cycles after edges 0..WIDTH−1.
  - RUN steps occur on edges 1..WIDTH.
  - quotient/remainder update and done=1 in the cycle after edge WIDTH.
  - busy=0 in that same cycle.
  - Latency start→done is WIDTH+1 edges; for WIDTH=8, done is high after edge 8 counting from edge 0 as the start edge.
- Divide by zero: done=1 and results valid in the cycle after edge 0. busy stays 0.
- Minimum issue interval: start is next accepted on the edge after the DONE cycle. That is every WIDTH+2 cycles, or every 2 cycles for divide-by-zero.
- Outputs are purely registered; there is no combinational path from inputs to outputs.

## Test plan

- WIDTH=8, dividend=200, divisor=7, start 1 cycle -> busy for 8 cycles, then done pulse with quotient=28, remainder=4, div_by_zero=0.
- 255/1 then 5/9 issued back-to-back at the earliest legal edge -> results 255 r0, then 0 r5. Each done is exactly 1 cycle wide.
- dividend=100, divisor=0 -> done in the cycle after start, quotient=255, remainder=100, div_by_zero=1, busy never high. A following 9/3 clears div_by_zero and gives 3 r0.
- start held high during RUN, with operands changed mid-run (200/7 → 10/2) -> the second request is ignored, result is 28 r4, and a start held during the DONE cycle is also ignored.
- rst_n=0 for one edge at step 4 of 200/7 -> next cycle all outputs 0, state IDLE, no done. A subsequent 17/5 yields 3 r2.
- Random sweep of 1000 operand pairs, divisor≠0 -> every result satisfies dividend = q·d + r with r < d.
